// File: rtl/mips_pkg.sv
// Shared MIPS-lite definitions: widths, reset PC, fetch FSM states and instruction layout.
package mips_pkg;

    localparam int unsigned ADDRESSWIDTH        = 32;
    localparam int unsigned INSTRUCTION_WIDTH   = 32;
    localparam int unsigned MEMDEPTH            = 4096;
    localparam int unsigned BYTESPERINSTRUCTION = 4;

    localparam logic [ADDRESSWIDTH-1:0]      RESET_PC  = 32'h0000_0000;
    localparam logic [INSTRUCTION_WIDTH-1:0] NOP_INSTR = 32'h0000_0000;

    // Fetch stage control state.
    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    // Instruction word layout as consumed by decode.
    typedef struct packed {
        logic [5:0] opcode;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
        logic [5:0] funct;
    } Instruct;

endpackage : mips_pkg

// File: rtl/fetch_stage_sat_counter.sv
// Saturating up-counter with enable and asynchronous active-low clear.
// Ports:
//   clk, rst_n : clock and asynchronous active-low clear
//   en         : count one when high (sticks at all-ones)
//   count      : current count value
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    // Increment unless already at the all-ones ceiling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule : sat_counter

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address and
// loads the IF/ID fetch buffer. Handles branch redirects, HALT and hazard stalls,
// and counts fetched instructions and stalled cycles.
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   stall_i                          : hold PC and fetch buffer
//   branch_taken_i, branch_target_i  : EX redirect (target bits [1:0] ignored)
//   halt_i                           : decode holds HALT
//   imem_addr_o / imem_rdata_i       : instruction memory (combinational read)
//   fb_valid_o, fb_pc_o, fb_instr_o  : fetch buffer towards decode
//   halted_o                         : fetch permanently stopped
//   fetch_count_o, stall_count_o     : saturating statistics
module fetch_stage #(
    parameter int unsigned ADDRESSWIDTH      = mips_pkg::ADDRESSWIDTH,
    parameter int unsigned INSTRUCTION_WIDTH = mips_pkg::INSTRUCTION_WIDTH,
    parameter int unsigned MEMDEPTH          = mips_pkg::MEMDEPTH,
    parameter int unsigned RESET_PC          = 32'(mips_pkg::RESET_PC)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         stall_i,
    input  logic                         branch_taken_i,
    input  logic [ADDRESSWIDTH-1:0]      branch_target_i,
    input  logic                         halt_i,
    output logic [ADDRESSWIDTH-1:0]      imem_addr_o,
    input  logic [INSTRUCTION_WIDTH-1:0] imem_rdata_i,
    output logic                         fb_valid_o,
    output logic [ADDRESSWIDTH-1:0]      fb_pc_o,
    output logic [INSTRUCTION_WIDTH-1:0] fb_instr_o,
    output logic                         halted_o,
    output logic [31:0]                  fetch_count_o,
    output logic [31:0]                  stall_count_o
);

    import mips_pkg::fetch_state_t;
    import mips_pkg::RUN;
    import mips_pkg::HALTED;
    import mips_pkg::NOP_INSTR;
    import mips_pkg::BYTESPERINSTRUCTION;

    localparam logic [ADDRESSWIDTH-1:0]      PC_RESET = ADDRESSWIDTH'(RESET_PC);
    localparam logic [ADDRESSWIDTH-1:0]      PC_MOD   = ADDRESSWIDTH'(MEMDEPTH);
    localparam logic [ADDRESSWIDTH-1:0]      PC_INC   = ADDRESSWIDTH'(BYTESPERINSTRUCTION);
    localparam logic [INSTRUCTION_WIDTH-1:0] NOP      = INSTRUCTION_WIDTH'(NOP_INSTR);

    fetch_state_t                  state_q, state_d;
    logic [ADDRESSWIDTH-1:0]       pc_q, pc_d;
    logic                          fb_valid_q, fb_valid_d;
    logic [ADDRESSWIDTH-1:0]       fb_pc_q, fb_pc_d;
    logic [INSTRUCTION_WIDTH-1:0]  fb_instr_q, fb_instr_d;
    logic                          fetch_en, stall_en;
    logic [ADDRESSWIDTH-1:0]       pc_seq, pc_branch;
    logic                          unused_target_lsbs;

    // Redirect target is word-aligned; the low two bits carry no information.
    assign unused_target_lsbs = ^branch_target_i[1:0];

    // Sequential and redirect PCs, both wrapped into the instruction memory.
    assign pc_seq    = (pc_q + PC_INC) % PC_MOD;
    assign pc_branch = {branch_target_i[ADDRESSWIDTH-1:2], 2'b00} % PC_MOD;

    // State and fetch-buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            pc_q       <= PC_RESET;
            fb_valid_q <= 1'b0;
            fb_pc_q    <= '0;
            fb_instr_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fb_valid_q <= fb_valid_d;
            fb_pc_q    <= fb_pc_d;
            fb_instr_q <= fb_instr_d;
        end
    end

    // Next-state logic; priority in RUN is branch > halt > stall > normal fetch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fb_valid_d = fb_valid_q;
        fb_pc_d    = fb_pc_q;
        fb_instr_d = fb_instr_q;
        fetch_en   = 1'b0;
        stall_en   = 1'b0;

        case (state_q)
            RUN: begin
                if (branch_taken_i) begin
                    // A concurrent HALT sits in the branch shadow and is dropped.
                    pc_d       = pc_branch;
                    fb_valid_d = 1'b0;
                    fb_instr_d = NOP;
                end else if (halt_i) begin
                    state_d    = HALTED;
                    fb_valid_d = 1'b0;
                    fb_instr_d = NOP;
                end else if (stall_i) begin
                    stall_en   = 1'b1;
                end else begin
                    fb_pc_d    = pc_q;
                    fb_instr_d = imem_rdata_i;
                    fb_valid_d = 1'b1;
                    pc_d       = pc_seq;
                    fetch_en   = 1'b1;
                end
            end
            HALTED: begin
                fb_valid_d = 1'b0;
                fb_instr_d = NOP;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    sat_counter #(.WIDTH(32)) u_fetch_count (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (fetch_en),
        .count (fetch_count_o)
    );

    sat_counter #(.WIDTH(32)) u_stall_count (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (stall_en),
        .count (stall_count_o)
    );

    assign imem_addr_o = pc_q;
    assign fb_valid_o  = fb_valid_q;
    assign fb_pc_o     = fb_pc_q;
    assign fb_instr_o  = fb_instr_q;
    assign halted_o    = (state_q == HALTED);

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: table of per-cycle vectors fed through an
// expectation queue, plus hand-written asynchronous-reset sequences.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i, branch_taken_i, halt_i;
    logic [31:0] branch_target_i;
    logic [31:0] imem_addr_o, imem_rdata_i;
    logic        fb_valid_o;
    logic [31:0] fb_pc_o, fb_instr_o;
    logic        halted_o;
    logic [31:0] fetch_count_o, stall_count_o;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int          idx;
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic        halt;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] fbpc;
        logic        halted;
        logic [31:0] fc;
        logic [31:0] sc;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    // Instruction memory model: every word is distinct and never equal to NOP.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    assign imem_rdata_i = mem_word(imem_addr_o);

    fetch_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_i         (stall_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .halt_i          (halt_i),
        .imem_addr_o     (imem_addr_o),
        .imem_rdata_i    (imem_rdata_i),
        .fb_valid_o      (fb_valid_o),
        .fb_pc_o         (fb_pc_o),
        .fb_instr_o      (fb_instr_o),
        .halted_o        (halted_o),
        .fetch_count_o   (fetch_count_o),
        .stall_count_o   (stall_count_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic stall, input logic br, input logic [31:0] tgt,
                       input logic halt, input logic [31:0] addr, input logic valid,
                       input logic [31:0] fbpc, input logic halted,
                       input logic [31:0] fc, input logic [31:0] sc);
        vec_t v;
        v.idx = vecs.size();
        v.stall = stall; v.br = br; v.tgt = tgt; v.halt = halt;
        v.addr = addr; v.valid = valid; v.fbpc = fbpc; v.halted = halted;
        v.fc = fc; v.sc = sc;
        vecs.push_back(v);
    endtask

    task automatic compare_exp(input vec_t e);
        logic [31:0] exp_instr;
        exp_instr = e.valid ? mem_word(e.fbpc) : 32'h0;
        check($sformatf("v%0d imem_addr", e.idx), imem_addr_o, e.addr);
        check($sformatf("v%0d fb_valid", e.idx), 32'(fb_valid_o), 32'(e.valid));
        if (e.valid) check($sformatf("v%0d fb_pc", e.idx), fb_pc_o, e.fbpc);
        check($sformatf("v%0d fb_instr", e.idx), fb_instr_o, exp_instr);
        check($sformatf("v%0d halted", e.idx), 32'(halted_o), 32'(e.halted));
        check($sformatf("v%0d fetch_count", e.idx), fetch_count_o, e.fc);
        check($sformatf("v%0d stall_count", e.idx), stall_count_o, e.sc);
    endtask

    task automatic check_reset(input string tag);
        check({tag, " imem_addr"}, imem_addr_o, 32'h0);
        check({tag, " fb_valid"}, 32'(fb_valid_o), 32'h0);
        check({tag, " fb_pc"}, fb_pc_o, 32'h0);
        check({tag, " fb_instr"}, fb_instr_o, 32'h0);
        check({tag, " halted"}, 32'(halted_o), 32'h0);
        check({tag, " fetch_count"}, fetch_count_o, 32'h0);
        check({tag, " stall_count"}, stall_count_o, 32'h0);
    endtask

    task automatic drive(input logic stall, input logic br, input logic [31:0] tgt, input logic halt);
        stall_i = stall; branch_taken_i = br; branch_target_i = tgt; halt_i = halt;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0);

        //   stall br  tgt           halt addr          v     fbpc          hlt  fc  sc
        add(1'b0, 1'b0, 32'h0,      1'b0, 32'h0000_0004, 1'b1, 32'h0000_0000, 1'b0, 1, 0);
        add(1'b0, 1'b0, 32'h0,      1'b0, 32'h0000_0008, 1'b1, 32'h0000_0004, 1'b0, 2, 0);
        add(1'b0, 1'b0, 32'h0,      1'b0, 32'h0000_000C, 1'b1, 32'h0000_0008, 1'b0, 3, 0);
        add(1'b1, 1'b0, 32'h0,      1'b0, 32'h0000_000C, 1'b1, 32'h0000_0008, 1'b0, 3, 1);
        add(1'b1, 1'b0, 32'h0,      1'b0, 32'h0000_000C, 1'b1, 32'h0000_0008, 1'b0, 3, 2);
        add(1'b0, 1'b0, 32'h0,      1'b0, 32'h0000_0010, 1'b1, 32'h0000_000C, 1'b0, 4, 2);
        add(1'b1, 1'b1, 32'h43,     1'b0, 32'h0000_0040, 1'b0, 32'h0,         1'b0, 4, 2);
        add(1'b0, 1'b0, 32'h0,      1'b0, 32'h0000_0044, 1'b1, 32'h0000_0040, 1'b0, 5, 2);
        add(1'b0, 1'b1, 32'h100,    1'b1, 32'h0000_0100, 1'b0, 32'h0,         1'b0, 5, 2);
        add(1'b0, 1'b0, 32'h0,      1'b0, 32'h0000_0104, 1'b1, 32'h0000_0100, 1'b0, 6, 2);
        add(1'b0, 1'b1, 32'hFFE,    1'b0, 32'h0000_0FFC, 1'b0, 32'h0,         1'b0, 6, 2);
        add(1'b0, 1'b0, 32'h0,      1'b0, 32'h0000_0000, 1'b1, 32'h0000_0FFC, 1'b0, 7, 2);
        add(1'b0, 1'b1, 32'h1234,   1'b0, 32'h0000_0234, 1'b0, 32'h0,         1'b0, 7, 2);
        add(1'b0, 1'b0, 32'h0,      1'b0, 32'h0000_0238, 1'b1, 32'h0000_0234, 1'b0, 8, 2);
        add(1'b1, 1'b0, 32'h0,      1'b1, 32'h0000_0238, 1'b0, 32'h0,         1'b1, 8, 2);
        add(1'b1, 1'b0, 32'h0,      1'b0, 32'h0000_0238, 1'b0, 32'h0,         1'b1, 8, 2);
        add(1'b0, 1'b1, 32'h80,     1'b0, 32'h0000_0238, 1'b0, 32'h0,         1'b1, 8, 2);
        add(1'b0, 1'b0, 32'h0,      1'b1, 32'h0000_0238, 1'b0, 32'h0,         1'b1, 8, 2);
        add(1'b0, 1'b0, 32'h0,      1'b0, 32'h0000_0238, 1'b0, 32'h0,         1'b1, 8, 2);

        #12;
        check_reset("por");

        // Table: compare the previous vector's result, then drive the next one.
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            if (exp_q.size() > 0) compare_exp(exp_q.pop_front());
            if (i == 0) rst_n = 1'b1;
            drive(vecs[i].stall, vecs[i].br, vecs[i].tgt, vecs[i].halt);
            exp_q.push_back(vecs[i]);
        end
        @(negedge clk);
        if (exp_q.size() > 0) compare_exp(exp_q.pop_front());
        drive(1'b0, 1'b0, 32'h0, 1'b0);

        // Asynchronous reset while HALTED: clears before any clock edge.
        #2 rst_n = 1'b0;
        #1 check_reset("rst_halted");

        // Restart and fetch, then reset asynchronously mid-run.
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("restart1 fb_pc", fb_pc_o, 32'h0);
        check("restart1 fb_instr", fb_instr_o, mem_word(32'h0));
        check("restart1 imem_addr", imem_addr_o, 32'h4);
        check("restart1 fetch_count", fetch_count_o, 32'h1);
        @(negedge clk);
        check("restart2 fb_pc", fb_pc_o, 32'h4);
        check("restart2 fetch_count", fetch_count_o, 32'h2);
        stall_i = 1'b1;
        @(negedge clk);
        check("restart_stall fb_pc", fb_pc_o, 32'h4);
        check("restart_stall imem_addr", imem_addr_o, 32'h8);
        check("restart_stall stall_count", stall_count_o, 32'h1);
        stall_i = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset("rst_run");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_fetch_stage
